// File: rtl/cdma_pkg.sv
// Shared Gold-code definitions for the CDMA spreader/despreader pair.
// Holds the LFSR tap masks, the seed width, FSM states and the generator step helpers.
package cdma_pkg;

  localparam int SEED_W = 5;

  localparam logic [SEED_W-1:0] TAPS_A = 5'b11110;
  localparam logic [SEED_W-1:0] TAPS_B = 5'b10010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } state_e;

  // Left shift with the masked parity of the old state entering at the LSB.
  function automatic logic [SEED_W-1:0] lfsr_step(input logic [SEED_W-1:0] s,
                                                  input logic [SEED_W-1:0] taps);
    return {s[SEED_W-2:0], ^(s & taps)};
  endfunction

  function automatic logic gold_chip(input logic [SEED_W-1:0] a,
                                     input logic [SEED_W-1:0] b);
    return a[SEED_W-1] ^ b[SEED_W-1];
  endfunction

endpackage

// File: rtl/cdma_despreader_if.sv
// Chip-stream, control and recovered-data signals of the despreader.
// slave is the despreader side; master is the chip source and bit consumer.
interface cdma_despreader_if;

  logic                        chip_i;
  logic                        chip_valid_i;
  logic [cdma_pkg::SEED_W-1:0] seed_i;
  logic                        load_i;
  logic                        bit_o;
  logic                        bit_valid_o;
  logic                        locked_o;
  logic                        gold_o;
  logic                        seed_err_o;
  cdma_pkg::state_e            state_o;
  logic [4:0]                  slip_cnt_o;

  modport slave (
    input  chip_i, chip_valid_i, seed_i, load_i,
    output bit_o, bit_valid_o, locked_o, gold_o, seed_err_o, state_o, slip_cnt_o
  );

  modport master (
    output chip_i, chip_valid_i, seed_i, load_i,
    input  bit_o, bit_valid_o, locked_o, gold_o, seed_err_o, state_o, slip_cnt_o
  );

endinterface

// File: rtl/cdma_despreader_gold_gen.sv
// Two-LFSR Gold chip generator; gold_o is combinational from the current state and
// reflects the chip for the next advance. Load has priority over advance.
module gold_gen
  import cdma_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [SEED_W-1:0] seed_i,
  input  logic              advance_i,
  output logic              gold_o
);

  logic [SEED_W-1:0] a_q, a_d;
  logic [SEED_W-1:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = seed_i;
      b_d = seed_i;
    end else if (advance_i) begin
      a_d = lfsr_step(a_q, TAPS_A);
      b_d = lfsr_step(b_q, TAPS_B);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign gold_o = gold_chip(a_q, b_q);

endmodule

// File: rtl/cdma_despreader.sv
// Gold-code despreader: correlates PERIOD-chip windows, recovers one bit per window and
// slips code phase until locked. Bit strobe is registered, one cycle after the last chip.
module cdma_despreader
  import cdma_pkg::*;
#(
  parameter int PERIOD      = 31,
  parameter int LOCK_THRESH = 28,
  parameter int MAX_MISS    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cdma_despreader_if.slave   io
);

  localparam logic [4:0] LAST_CHIP = 5'(PERIOD - 1);
  localparam logic [4:0] THR_ZERO  = 5'(LOCK_THRESH);
  localparam logic [4:0] THR_ONE   = 5'(PERIOD - LOCK_THRESH);
  localparam logic [2:0] MISS_LIM  = 3'(MAX_MISS);

  state_e     state_q, state_d;
  logic [4:0] chip_cnt_q, chip_cnt_d;
  logic [4:0] agree_cnt_q, agree_cnt_d;
  logic [4:0] slip_cnt_q, slip_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       slip_arm_q, slip_arm_d;
  logic       bit_q, bit_d;
  logic       bit_vld_q, bit_vld_d;
  logic       seed_err_q, seed_err_d;

  logic       gold;
  logic       accept;
  logic       count_chip;
  logic       win_end;
  logic       dec_zero;
  logic       dec_one;
  logic [4:0] agree_nxt;

  gold_gen u_gold_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (io.load_i),
    .seed_i    (io.seed_i),
    .advance_i (count_chip),
    .gold_o    (gold)
  );

  // A slipped chip is accepted but neither counted nor used to advance the generator.
  always_comb begin
    accept     = io.chip_valid_i && !io.load_i && (state_q != IDLE);
    count_chip = accept && !slip_arm_q;
    agree_nxt  = agree_cnt_q + {4'd0, ~(io.chip_i ^ gold)};
    win_end    = count_chip && (chip_cnt_q == LAST_CHIP);
    dec_zero   = agree_nxt >= THR_ZERO;
    dec_one    = agree_nxt <= THR_ONE;
  end

  always_comb begin
    state_d     = state_q;
    chip_cnt_d  = chip_cnt_q;
    agree_cnt_d = agree_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    slip_arm_d  = slip_arm_q;
    bit_d       = bit_q;
    bit_vld_d   = 1'b0;
    seed_err_d  = seed_err_q;

    if (io.load_i) begin
      chip_cnt_d  = '0;
      agree_cnt_d = '0;
      slip_cnt_d  = '0;
      miss_cnt_d  = '0;
      slip_arm_d  = 1'b0;
      seed_err_d  = (io.seed_i == '0);
      state_d     = (io.seed_i == '0) ? IDLE : SEARCH;
    end else if (accept && slip_arm_q) begin
      slip_arm_d = 1'b0;
    end else if (count_chip && !win_end) begin
      chip_cnt_d  = chip_cnt_q + 5'd1;
      agree_cnt_d = agree_nxt;
    end else if (win_end) begin
      chip_cnt_d  = '0;
      agree_cnt_d = '0;
      if (dec_zero || dec_one) begin
        bit_vld_d  = 1'b1;
        bit_d      = !dec_zero;
        miss_cnt_d = '0;
        state_d    = TRACK;
      end else if (state_q == SEARCH) begin
        slip_arm_d = 1'b1;
        slip_cnt_d = (slip_cnt_q == LAST_CHIP) ? 5'd0 : slip_cnt_q + 5'd1;
      end else if (miss_cnt_q + 3'd1 == MISS_LIM) begin
        // Lock lost: restart acquisition from the current phase with fresh counters.
        miss_cnt_d = '0;
        slip_cnt_d = '0;
        state_d    = SEARCH;
      end else begin
        miss_cnt_d = miss_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      chip_cnt_q  <= '0;
      agree_cnt_q <= '0;
      slip_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      slip_arm_q  <= 1'b0;
      bit_q       <= 1'b0;
      bit_vld_q   <= 1'b0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_cnt_q  <= chip_cnt_d;
      agree_cnt_q <= agree_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      slip_arm_q  <= slip_arm_d;
      bit_q       <= bit_d;
      bit_vld_q   <= bit_vld_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign io.bit_o       = bit_q;
  assign io.bit_valid_o = bit_vld_q;
  assign io.locked_o    = (state_q == TRACK);
  assign io.gold_o      = gold;
  assign io.seed_err_o  = seed_err_q;
  assign io.state_o     = state_q;
  assign io.slip_cnt_o  = slip_cnt_q;

endmodule
